// File: rtl/addac_acc_n.sv
// Parametrised ADDAC accumulator: hold/load/add/sub with optional saturation,
// sticky overflow and a burst counter that pulses done every BURST add/sub ops.
module addac_acc_n #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned BURST    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           sel0,
    input  logic                           sel1,
    input  logic [WIDTH-1:0]               a,
    output logic [WIDTH-1:0]               s,
    output logic                           cout,
    output logic                           ovf,
    output logic                           done,
    output logic [$clog2(BURST+1)-1:0]     cnt
);

    localparam int unsigned CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BurstLast = CW'(BURST - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_d;
    logic             cout_d, ovf_d, done_d;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH:0]   sum, diff;
    logic             arith;

    // MSB of the widened sum/difference is the carry/borrow.
    assign sum  = {1'b0, s} + {1'b0, a};
    assign diff = {1'b0, s} - {1'b0, a};

    always_comb begin
        s_d     = s;
        cout_d  = cout;
        ovf_d   = ovf;
        done_d  = 1'b0;
        cnt_d   = cnt;
        state_d = state_q;
        arith   = 1'b0;

        if (in_valid) begin
            case ({sel1, sel0})
                2'b01: begin
                    s_d     = a;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
                2'b10: begin
                    arith  = 1'b1;
                    cout_d = sum[WIDTH];
                    ovf_d  = ovf | sum[WIDTH];
                    s_d    = (SATURATE != 0 && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                end
                2'b11: begin
                    arith  = 1'b1;
                    cout_d = diff[WIDTH];
                    ovf_d  = ovf | diff[WIDTH];
                    s_d    = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
                end
                default: ;
            endcase
        end

        if (arith) begin
            case (state_q)
                StIdle: begin
                    if (BURST == 1) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (cnt == BurstLast) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            s       <= s_d;
            cout    <= cout_d;
            ovf     <= ovf_d;
            done    <= done_d;
            cnt     <= cnt_d;
        end
    end

endmodule
